// File: rtl/acti_share_sched_if.sv
// Bus between the PE-column accumulators, the activation scheduler and the
// activation unit. The scheduler uses the master view; the column/activation
// side uses the slave view.
interface acti_share_sched_if #(
  parameter int DW    = 32,
  parameter int N_REQ = 4
);
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*2*DW-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  act_valid;
  logic [2*DW-1:0]       act_data;
  logic [1:0]            act_mode;
  logic [3:0]            act_layer;
  logic                  act_done;
  logic [SRC_W-1:0]      res_src;

  modport master (
    input  req_valid, req_data, act_done,
    output req_ready, act_valid, act_data, act_mode, act_layer, res_src
  );

  modport slave (
    output req_valid, req_data, act_done,
    input  req_ready, act_valid, act_data, act_mode, act_layer, res_src
  );
endinterface

// File: rtl/acti_share_sched.sv
// Round-robin scheduler sharing one activation unit among N_REQ column result
// streams. Latches the layer configuration when a layer is accepted, issues
// one result per cycle to the activation unit, tags each returned result with
// its source column and pulses layer_done once every result has come back.
module acti_share_sched #(
  parameter int DW    = 32,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             layer_start,
  input  logic [3:0]       cfg_layer,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_len,
  acti_share_sched_if.master bus,
  output logic             busy,
  output logic             layer_done
);

  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q;
  logic [1:0]        mode_q;
  logic [3:0]        layer_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  returned_q;
  logic [SRC_W-1:0]  ptr_q;
  logic              act_valid_q;
  logic [2*DW-1:0]   act_data_q;
  logic [SRC_W-1:0]  tag1_q;
  logic [SRC_W-1:0]  tag2_q;

  logic              start_acc;
  logic              grant_any;
  logic              grant_en;
  logic              done_acc;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  ptr_next;
  logic [SRC_W:0]    scan_sum;
  logic [SRC_W-1:0]  scan_idx;
  logic [N_REQ-1:0]  ready_vec;
  logic [2*DW-1:0]   sel_data;

  // A layer is accepted only from IDLE; config is captured on that same edge
  // so CONFIG already sees the latched length.
  assign start_acc = (state_q == ST_IDLE) && layer_start;

  // Results returning outside a layer, or beyond the layer length, are dropped.
  assign done_acc  = bus.act_done && ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                     (returned_q != len_q);

  // Round-robin scan starting at ptr: first valid column wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (scan_sum >= (SRC_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (SRC_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[SRC_W-1:0];
      if (!grant_any && bus.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign grant_en = (state_q == ST_RUN) && grant_any && (issued_q != len_q);
  assign ptr_next = (grant_idx == SRC_W'(N_REQ-1)) ? '0 : grant_idx + SRC_W'(1);

  // One-hot grant and the granted column's operand.
  always_comb begin
    ready_vec = '0;
    sel_data  = '0;
    if (grant_en) begin
      ready_vec[grant_idx] = 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_data = bus.req_data[i*2*DW +: 2*DW];
      end
    end
  end

  // Next-state logic for the layer sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (layer_start) state_d = ST_CONFIG;
      ST_CONFIG: state_d = (len_q == '0) ? ST_DONE : ST_RUN;
      ST_RUN:    if (grant_en && ((issued_q + CNT_W'(1)) == len_q)) state_d = ST_DRAIN;
      ST_DRAIN:  if ((returned_q == len_q) ||
                     (done_acc && ((returned_q + CNT_W'(1)) == len_q))) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Layer configuration, held until the next accepted layer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      mode_q  <= '0;
      layer_q <= '0;
    end else if (start_acc) begin
      len_q   <= cfg_len;
      mode_q  <= cfg_mode;
      layer_q <= cfg_layer;
    end
  end

  // Issued/returned counters, cleared when a new layer is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q   <= '0;
      returned_q <= '0;
    end else if (start_acc) begin
      issued_q   <= '0;
      returned_q <= '0;
    end else begin
      if (grant_en) issued_q   <= issued_q + CNT_W'(1);
      if (done_acc) returned_q <= returned_q + CNT_W'(1);
    end
  end

  // Round-robin pointer moves just past the last granted column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ptr_q <= '0;
    else if (grant_en) ptr_q <= ptr_next;
  end

  // Issue stage plus two-deep source tag pipe matching the fixed unit latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_valid_q <= 1'b0;
      act_data_q  <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
    end else begin
      act_valid_q <= grant_en;
      act_data_q  <= grant_en ? sel_data : '0;
      if (grant_en) tag1_q <= grant_idx;
      tag2_q      <= tag1_q;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.act_valid = act_valid_q;
  assign bus.act_data  = act_data_q;
  assign bus.act_mode  = mode_q;
  assign bus.act_layer = layer_q;
  assign bus.res_src   = tag2_q;
  assign busy          = (state_q != ST_IDLE);
  assign layer_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_acti_share_sched.sv
// Directed bench for the activation scheduler: a per-cycle vector table for
// fairness, zero-length and sparse layers, plus hand sequences for reset,
// config hold and randomly gapped requests.
module tb_acti_share_sched;

  localparam int DW    = 32;
  localparam int N_REQ = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             layer_start;
  logic [3:0]       cfg_layer;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_len;
  logic             busy;
  logic             layer_done;
  logic             done_pipe;

  int n_checks = 0;
  int n_fail   = 0;

  acti_share_sched_if #(.DW(DW), .N_REQ(N_REQ)) bus ();

  acti_share_sched #(.DW(DW), .N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .layer_start(layer_start),
    .cfg_layer  (cfg_layer),
    .cfg_mode   (cfg_mode),
    .cfg_len    (cfg_len),
    .bus        (bus),
    .busy       (busy),
    .layer_done (layer_done)
  );

  // Clock generator.
  always #5 clk = ~clk;

  // Activation unit model: one cycle from strobe to finish flag.
  always @(posedge clk or posedge rst) begin
    if (rst) done_pipe <= 1'b0;
    else     done_pipe <= bus.act_valid;
  end
  assign bus.act_done = done_pipe;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic             ls;
    logic [CNT_W-1:0] len;
    logic [1:0]       mode;
    logic [3:0]       layer;
    logic [3:0]       valid;
    logic [3:0]       exp_ready;
    logic             exp_av;
    logic             exp_busy;
    logic             exp_ld;
    logic             chk_cfg;
    logic [1:0]       exp_mode;
    logic [3:0]       exp_layer;
    logic             chk_res;
    logic [1:0]       exp_res;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [2*DW-1:0] colData(input int i);
    return {16'hC0DE, 16'(i), 32'h1234_0000 + 32'(i)};
  endfunction

  function automatic int onehotIdx(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic addVec(input logic ls, input int len, input logic [1:0] mode,
                        input logic [3:0] layer, input logic [3:0] valid,
                        input logic [3:0] exp_ready, input logic exp_av,
                        input logic exp_busy, input logic exp_ld, input logic chk_cfg,
                        input logic [1:0] exp_mode, input logic [3:0] exp_layer,
                        input logic chk_res, input logic [1:0] exp_res);
    vec_t v;
    v.ls = ls; v.len = CNT_W'(len); v.mode = mode; v.layer = layer; v.valid = valid;
    v.exp_ready = exp_ready; v.exp_av = exp_av; v.exp_busy = exp_busy; v.exp_ld = exp_ld;
    v.chk_cfg = chk_cfg; v.exp_mode = exp_mode; v.exp_layer = exp_layer;
    v.chk_res = chk_res; v.exp_res = exp_res;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    layer_start   = v.ls;
    cfg_len       = v.len;
    cfg_mode      = v.mode;
    cfg_layer     = v.layer;
    bus.req_valid = v.valid;
  endtask

  initial begin
    int prev_g;
    int done_k;
    int cfg_err;
    int grants, avs, bad_ready, src_err, extra;
    logic got_ld;
    int q_src[$];
    logic [2*DW-1:0] exp_data;

    rst = 1'b1;
    layer_start = 1'b0; cfg_layer = '0; cfg_mode = '0; cfg_len = '0;
    bus.req_valid = '0;
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*2*DW +: 2*DW] = colData(i);

    // ---------------- reset state ----------------
    @(negedge clk); #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("rst_act_valid", 64'(bus.act_valid), 64'd0);
    checkOutput("rst_act_mode", 64'(bus.act_mode), 64'd0);
    checkOutput("rst_act_layer", 64'(bus.act_layer), 64'd0);
    checkOutput("rst_layer_done", 64'(layer_done), 64'd0);
    rst = 1'b0;

    // ---------------- T1: reset mid-RUN ----------------
    @(negedge clk);
    layer_start = 1'b1; cfg_len = 16'd8; cfg_mode = 2'b01; cfg_layer = 4'd9;
    bus.req_valid = 4'hF;
    @(negedge clk); layer_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t1_running", 64'(bus.act_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t1_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("t1_act_valid", 64'(bus.act_valid), 64'd0);
    checkOutput("t1_act_data", 64'(bus.act_data), 64'd0);
    checkOutput("t1_act_mode", 64'(bus.act_mode), 64'd0);
    checkOutput("t1_act_layer", 64'(bus.act_layer), 64'd0);
    checkOutput("t1_busy", 64'(busy), 64'd0);
    checkOutput("t1_res_src", 64'(bus.res_src), 64'd0);
    @(negedge clk); rst = 1'b0;
    bus.req_valid = 4'h0;
    got_ld = 1'b0; extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      if (layer_done) got_ld = 1'b1;
      if (busy) extra++;
    end
    checkOutput("t1_no_layer_done", 64'(got_ld), 64'd0);
    checkOutput("t1_stays_idle", 64'(extra), 64'd0);

    // ---------------- table: T2 fairness ----------------
    addVec(1, 8, 2'b01, 4'd5, 4'hF, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h0, 0, 1, 0, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h1, 0, 1, 0, 1, 2'b01, 4'd5, 0, 0);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h2, 1, 1, 0, 1, 2'b01, 4'd5, 0, 0);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h4, 1, 1, 0, 1, 2'b01, 4'd5, 1, 0);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h8, 1, 1, 0, 1, 2'b01, 4'd5, 1, 1);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h1, 1, 1, 0, 1, 2'b01, 4'd5, 1, 2);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h2, 1, 1, 0, 1, 2'b01, 4'd5, 1, 3);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h4, 1, 1, 0, 1, 2'b01, 4'd5, 1, 0);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h8, 1, 1, 0, 1, 2'b01, 4'd5, 1, 1);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h0, 1, 1, 0, 1, 2'b01, 4'd5, 1, 2);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h0, 0, 1, 0, 1, 2'b01, 4'd5, 1, 3);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h0, 0, 1, 1, 1, 2'b01, 4'd5, 0, 0);
    addVec(0, 8, 2'b01, 4'd5, 4'hF, 4'h0, 0, 0, 0, 1, 2'b01, 4'd5, 0, 0);
    // ---------------- table: T4 zero length ----------------
    addVec(1, 0, 2'b00, 4'd2, 4'hF, 4'h0, 0, 0, 0, 1, 2'b01, 4'd5, 0, 0);
    addVec(0, 0, 2'b00, 4'd2, 4'hF, 4'h0, 0, 1, 0, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 0, 2'b00, 4'd2, 4'hF, 4'h0, 0, 1, 1, 1, 2'b00, 4'd2, 0, 0);
    addVec(0, 0, 2'b00, 4'd2, 4'hF, 4'h0, 0, 0, 0, 1, 2'b00, 4'd2, 0, 0);
    // ---------------- table: T3 sparse, only column 2 ----------------
    addVec(1, 3, 2'b01, 4'd7, 4'h4, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 3, 2'b01, 4'd7, 4'h4, 4'h0, 0, 1, 0, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 3, 2'b01, 4'd7, 4'h4, 4'h4, 0, 1, 0, 1, 2'b01, 4'd7, 0, 0);
    addVec(0, 3, 2'b01, 4'd7, 4'h4, 4'h4, 1, 1, 0, 1, 2'b01, 4'd7, 0, 0);
    addVec(0, 3, 2'b01, 4'd7, 4'h4, 4'h4, 1, 1, 0, 1, 2'b01, 4'd7, 1, 2);
    addVec(0, 3, 2'b01, 4'd7, 4'h4, 4'h0, 1, 1, 0, 1, 2'b01, 4'd7, 1, 2);
    addVec(0, 3, 2'b01, 4'd7, 4'h4, 4'h0, 0, 1, 0, 1, 2'b01, 4'd7, 1, 2);
    addVec(0, 3, 2'b01, 4'd7, 4'h4, 4'h0, 0, 1, 1, 1, 2'b01, 4'd7, 0, 0);
    addVec(0, 3, 2'b01, 4'd7, 4'h4, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0);
    // ---------------- table: pointer left at 3 after sparse layer ----------------
    addVec(1, 1, 2'b00, 4'd0, 4'hF, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 1, 2'b00, 4'd0, 4'hF, 4'h0, 0, 1, 0, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 1, 2'b00, 4'd0, 4'hF, 4'h8, 0, 1, 0, 1, 2'b00, 4'd0, 0, 0);
    addVec(0, 1, 2'b00, 4'd0, 4'hF, 4'h0, 1, 1, 0, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 1, 2'b00, 4'd0, 4'hF, 4'h0, 0, 1, 0, 0, 2'b00, 4'd0, 1, 3);
    addVec(0, 1, 2'b00, 4'd0, 4'hF, 4'h0, 0, 1, 1, 0, 2'b00, 4'd0, 0, 0);
    addVec(0, 1, 2'b00, 4'd0, 4'hF, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 0, 0);

    prev_g = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      exp_data = vecs[i].exp_av ? colData(prev_g) : '0;
      checkOutput($sformatf("row%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].exp_ready));
      checkOutput($sformatf("row%0d_act_valid", i), 64'(bus.act_valid), 64'(vecs[i].exp_av));
      checkOutput($sformatf("row%0d_act_data", i), 64'(bus.act_data), 64'(exp_data));
      checkOutput($sformatf("row%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      checkOutput($sformatf("row%0d_layer_done", i), 64'(layer_done), 64'(vecs[i].exp_ld));
      if (vecs[i].chk_cfg) begin
        checkOutput($sformatf("row%0d_act_mode", i), 64'(bus.act_mode), 64'(vecs[i].exp_mode));
        checkOutput($sformatf("row%0d_act_layer", i), 64'(bus.act_layer), 64'(vecs[i].exp_layer));
      end
      if (vecs[i].chk_res) begin
        checkOutput($sformatf("row%0d_act_done", i), 64'(bus.act_done), 64'd1);
        checkOutput($sformatf("row%0d_res_src", i), 64'(bus.res_src), 64'(vecs[i].exp_res));
      end
      if (vecs[i].exp_ready != 4'h0) prev_g = onehotIdx(vecs[i].exp_ready);
    end

    // ---------------- T5: config hold, mid-layer start ignored ----------------
    @(negedge clk);
    layer_start = 1'b1; cfg_len = 16'd6; cfg_mode = 2'b01; cfg_layer = 4'd3;
    bus.req_valid = 4'hF;
    done_k = 0; cfg_err = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      layer_start = (k == 4);
      if (k == 4) begin
        cfg_len = 16'd1; cfg_mode = 2'b10; cfg_layer = 4'd12;
      end
      #1;
      if (k >= 2 && (bus.act_mode != 2'b01 || bus.act_layer != 4'd3)) cfg_err++;
      if (layer_done) begin
        done_k = k;
        break;
      end
    end
    checkOutput("t5_done_cycle", 64'(done_k), 64'd10);
    checkOutput("t5_cfg_held", 64'(cfg_err), 64'd0);
    @(negedge clk); layer_start = 1'b0; #1;
    checkOutput("t5_idle_after", 64'(busy), 64'd0);
    checkOutput("t5_act_mode", 64'(bus.act_mode), 64'd1);
    checkOutput("t5_act_layer", 64'(bus.act_layer), 64'd3);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t5_no_second_layer", 64'(busy), 64'd0);

    // ---------------- T6: randomly gapped requests ----------------
    grants = 0; avs = 0; bad_ready = 0; src_err = 0; got_ld = 1'b0;
    q_src.delete();
    cfg_len = 16'd20; cfg_mode = 2'b00; cfg_layer = 4'd1;
    for (int c = 0; c < 300 && !got_ld; c++) begin
      @(negedge clk);
      layer_start = (c == 0);
      bus.req_valid = 4'($urandom_range(0, 15));
      #1;
      if ((bus.req_ready & ~bus.req_valid) != 4'h0 || !$onehot0(bus.req_ready)) bad_ready++;
      if (bus.req_ready != 4'h0) begin
        grants++;
        q_src.push_back(onehotIdx(bus.req_ready));
      end
      if (bus.act_valid) avs++;
      if (bus.act_done) begin
        if (q_src.size() == 0) src_err++;
        else if (int'(bus.res_src) != q_src.pop_front()) src_err++;
      end
      if (layer_done) got_ld = 1'b1;
    end
    checkOutput("t6_layer_done_seen", 64'(got_ld), 64'd1);
    checkOutput("t6_grant_count", 64'(grants), 64'd20);
    checkOutput("t6_strobe_count", 64'(avs), 64'd20);
    checkOutput("t6_grant_legal", 64'(bad_ready), 64'd0);
    checkOutput("t6_res_src_order", 64'(src_err), 64'd0);
    checkOutput("t6_all_returned", 64'(q_src.size()), 64'd0);
    extra = 0;
    layer_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.req_valid = 4'($urandom_range(1, 15));
      #1;
      if (bus.req_ready != 4'h0) extra++;
    end
    checkOutput("t6_no_grant_after", 64'(extra), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
